// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the five-stage core pipeline registers.
//   - Indices of each stage's bit in the global stall vector.
//   - Width of that stall vector.
//   - Action codes that every pipeline slot understands.
//   - Payload widths of the individual inter-stage buses.
//   - decode_action(): turns flush/up/dn into one action code.
package pipe_pkg;

  // Position of each stage's bit in the shared stall vector
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = 6;

  // Payload widths of the concatenated stage fields for each boundary
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 48;
  localparam int EX_MEM_W = 40;
  localparam int MEM_WB_W = 38;

  // What every slot of a stage register does on the coming edge
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  // Priority: flush, then loading whenever upstream is free, then a bubble
  // when only upstream is stalled, and a full hold when downstream is
  // stalled as well.
  function automatic act_e decode_action(input logic flush,
                                         input logic up,
                                         input logic dn);
    act_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (!up) begin
      act = ACT_LOAD;
    end else if (!dn) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
// Bundles the upstream payload, the stall/flush controls and the
// downstream payload/counter of one pipeline stage register.
//   master : drives in_data, in_valid, stall_en, flush, cnt_clr;
//            observes out_data, out_valid, stall_cnt
//   slave  : the stage register itself (inverse directions)
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 48,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic [STALL_W-1:0] stall_en;
  logic               flush;
  logic               cnt_clr;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_data,
    output in_valid,
    output stall_en,
    output flush,
    output cnt_clr,
    input  out_data,
    input  out_valid,
    input  stall_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  stall_en,
    input  flush,
    input  cnt_clr,
    output out_data,
    output out_valid,
    output stall_cnt
  );

endinterface

// File: rtl/pipe_slot.sv
// pipe_slot
// One payload+valid register of a pipeline stage register.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high, loads BUBBLE / invalid
//   act        : action for the coming edge (shared by all slots)
//   next_data  : value taken on LOAD or BUBBLE
//   next_valid : valid bit taken on LOAD or BUBBLE
//   slot_data  : registered payload
//   slot_valid : registered valid bit
// The caller decides what "next" means: slot 0 receives either the
// upstream payload or the bubble value, later slots receive the previous
// slot, so LOAD and BUBBLE look identical from inside a slot.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 48,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  act_e              act,
  input  logic [DATA_W-1:0] next_data,
  input  logic              next_valid,
  output logic [DATA_W-1:0] slot_data,
  output logic              slot_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_data  <= BUBBLE;
      slot_valid <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          slot_data  <= BUBBLE;
          slot_valid <= 1'b0;
        end
        ACT_LOAD, ACT_BUBBLE: begin
          slot_data  <= next_data;
          slot_valid <= next_valid;
        end
        default: begin
          slot_data  <= slot_data;
          slot_valid <= slot_valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic inter-stage pipeline register: an opaque payload plus a valid
// bit, DEPTH slots deep, steered by two bits of the global stall vector.
//   clk           : rising-edge clock
//   reset         : asynchronous active-high, clears every slot and counter
//   bus.in_data   : payload from the upstream stage
//   bus.in_valid  : upstream payload is a real instruction
//   bus.stall_en  : global stall vector, bit k stalls stage k
//   bus.flush     : synchronous kill of every slot
//   bus.cnt_clr   : synchronous clear of the stall counter
//   bus.out_data  : payload of the last slot
//   bus.out_valid : valid bit of the last slot
//   bus.stall_cnt : saturating count of edges with the upstream stage stalled
// Parameters: DATA_W payload width, STAGE upstream index in stall_en,
// STALL_W stall vector width, DEPTH slot count (1..4), BUBBLE value loaded
// on bubble/flush/reset, CNT_W counter width.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 48,
  parameter int                STAGE   = 2,
  parameter int                STALL_W = 6,
  parameter int                DEPTH   = 1,
  parameter logic [DATA_W-1:0] BUBBLE  = '0,
  parameter int                CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  // Elaboration-time parameter sanity checks
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be within 1..4");
  end
  if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be within 0..STALL_W-2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              up;
  logic              dn;
  act_e              act;
  logic [DATA_W-1:0] nxt_data   [DEPTH];
  logic              nxt_valid  [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];
  logic              slot_valid [DEPTH];
  logic [CNT_W-1:0]  cnt;

  // Only our own stage bit and the one downstream of it matter
  assign up  = bus.stall_en[STAGE];
  assign dn  = bus.stall_en[STAGE+1];
  assign act = decode_action(bus.flush, up, dn);

  // Slot 0 takes the upstream payload on LOAD and the bubble otherwise;
  // the slot ignores next_* on HOLD and FLUSH anyway.
  assign nxt_data[0]  = (act == ACT_LOAD) ? bus.in_data  : BUBBLE;
  assign nxt_valid[0] = (act == ACT_LOAD) ? bus.in_valid : 1'b0;

  // Later slots always shift from their predecessor, valid or not, so an
  // invalid entry keeps its place instead of being squeezed out.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i > 0) begin : g_chain
      assign nxt_data[i]  = slot_data[i-1];
      assign nxt_valid[i] = slot_valid[i-1];
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .act        (act),
      .next_data  (nxt_data[i]),
      .next_valid (nxt_valid[i]),
      .slot_data  (slot_data[i]),
      .slot_valid (slot_valid[i])
    );
  end

  // The counter follows the upstream stall bit alone (BUBBLE or HOLD),
  // so a coincident flush neither stops nor resets it; clear beats count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.cnt_clr) begin
      cnt <= '0;
    end else if (up && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.out_data  = slot_data[DEPTH-1];
  assign bus.out_valid = slot_valid[DEPTH-1];
  assign bus.stall_cnt = cnt;

endmodule
